// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle RV32I control FSM (fetch/decode/exec/mem/writeback).
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state
);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd7;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;

    localparam logic [CNT_W-1:0] c_limit   = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic             c_to_en   = (MEM_TIMEOUT != 0);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_illegal;
    logic             r_timeout;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_load, w_is_store, w_is_branch, w_is_jump, w_legal;
    logic       w_waiting, w_expired;
    logic [2:0] w_imm_sel;
    logic [1:0] w_src_a;
    logic       w_src_b;
    logic       w_unused_instr;

    // Only the opcode and funct3 fields steer control; the rest feed the datapath.
    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_unused_instr = ^{instr[31:15], instr[11:7]};

    assign w_is_load   = (w_opcode == c_op_load);
    assign w_is_store  = (w_opcode == c_op_store);
    assign w_is_branch = (w_opcode == c_op_branch);
    assign w_is_jump   = (w_opcode == c_op_jal) || (w_opcode == c_op_jalr);
    assign w_legal     = w_is_load || w_is_store || w_is_branch || w_is_jump ||
                         (w_opcode == c_op_lui) || (w_opcode == c_op_auipc) ||
                         (w_opcode == c_op_opimm) || (w_opcode == c_op_op);

    // A memory wait is any FETCH/MEM cycle without a completion; ready at the limit still wins.
    assign w_waiting = ((r_state == c_st_fetch) || (r_state == c_st_mem)) && !mem_ready;
    assign w_expired = c_to_en && (r_wait_cnt == c_limit);

    always_comb begin
        w_imm_sel = 3'd0;
        w_src_a   = 2'd0;
        w_src_b   = 1'b1;
        case (w_opcode)
            c_op_op:     w_src_b   = 1'b0;
            c_op_opimm:  w_imm_sel = ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) ? 3'd1 : 3'd0;
            c_op_store:  w_imm_sel = 3'd2;
            c_op_lui:    begin w_src_a = 2'd2; w_imm_sel = 3'd4; end
            c_op_auipc:  begin w_src_a = 2'd1; w_imm_sel = 3'd4; end
            c_op_jal:    begin w_src_a = 2'd1; w_imm_sel = 3'd5; end
            c_op_branch: begin w_src_b = 1'b0; w_imm_sel = 3'd3; end
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_fetch;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!w_waiting) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_cnt_max) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if ((r_state == c_st_decode) && !w_legal) begin
                r_illegal <= 1'b1;
            end
            if (w_waiting && w_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch: begin
                if (mem_ready)      w_next = c_st_decode;
                else if (w_expired) w_next = c_st_halt;
            end
            c_st_decode: w_next = w_legal ? c_st_exec : c_st_halt;
            c_st_exec: begin
                if (w_is_branch)                   w_next = c_st_fetch;
                else if (w_is_load || w_is_store)  w_next = c_st_mem;
                else                               w_next = c_st_wb;
            end
            c_st_mem: begin
                if (mem_ready)      w_next = w_is_load ? c_st_wb : c_st_fetch;
                else if (w_expired) w_next = c_st_halt;
            end
            c_st_wb:   w_next = c_st_fetch;
            c_st_halt: w_next = c_st_halt;
            default:   w_next = c_st_halt;
        endcase
    end

    // Every output is forced low while rst is high so an abandoned request never leaks out.
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        imm_sel   = 3'd0;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        wb_sel    = 2'd0;
        illegal   = 1'b0;
        timeout   = 1'b0;
        state     = 3'd0;
        if (!rst) begin
            illegal = r_illegal;
            timeout = r_timeout;
            state   = r_state;
            case (r_state)
                c_st_fetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                c_st_exec: begin
                    imm_sel   = w_imm_sel;
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    if (w_is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = br_taken ? 2'd2 : 2'd0;
                    end
                end
                c_st_mem: begin
                    imm_sel   = w_imm_sel;
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    mem_req   = 1'b1;
                    mem_we    = w_is_store;
                    pc_write  = w_is_store && mem_ready;
                end
                c_st_wb: begin
                    imm_sel   = w_imm_sel;
                    alu_src_a = w_src_a;
                    alu_src_b = w_src_b;
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = w_is_jump ? 2'd1 : 2'd0;
                    wb_sel    = w_is_load ? 2'd1 : (w_is_jump ? 2'd2 : 2'd0);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for mc_ctrl with a per-instruction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int c_to = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        br_taken;
    logic        ir_write, pc_write, mem_req, mem_we, reg_write, alu_src_b, illegal, timeout;
    logic [1:0]  pc_src, alu_src_a, wb_sel;
    logic [2:0]  imm_sel, state;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(c_to), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
        .mem_we(mem_we), .reg_write(reg_write), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .wb_sel(wb_sel), .illegal(illegal), .timeout(timeout),
        .state(state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       mreq;
        logic       mwe;
        logic       rw;
        logic [1:0] wbs;
        logic       ill;
        logic       to;
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
    } obs_t;

    typedef struct {
        obs_t o;
        logic sel_ok;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_name = "reset";
    int    cur_cyc  = 0;
    logic  m_ill    = 1'b0;
    logic  m_to     = 1'b0;
    exp_t  cmp_x;
    obs_t  cmp_act, cmp_mask;

    // pc_src/wb_sel only matter with their enable; operand selects only in EXEC/MEM.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_x   = exp_q.pop_front();
            cmp_act = {state, ir_write, pc_write, pc_src, mem_req, mem_we, reg_write,
                       wb_sel, illegal, timeout, imm_sel, alu_src_a, alu_src_b};
            cmp_mask = '1;
            if (!cmp_x.o.pcw) cmp_mask.pcs = 2'b00;
            if (!cmp_x.o.rw)  cmp_mask.wbs = 2'b00;
            if (!cmp_x.sel_ok) begin
                cmp_mask.imm = 3'b000;
                cmp_mask.a   = 2'b00;
                cmp_mask.b   = 1'b0;
            end
            n_checks++;
            if ((cmp_act & cmp_mask) == (cmp_x.o & cmp_mask)) n_pass++;
            else $display("FAIL %s cyc%0d: outputs %h, required %h (care mask %h)",
                          cur_name, cur_cyc, cmp_act, cmp_x.o, cmp_mask);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.ill = m_ill;
        o.to  = m_to;
        return o;
    endfunction

    task automatic step(input logic r, input logic rd, input logic br, input obs_t o, input logic sel);
        exp_t x;
        rst       = r;
        mem_ready = rd;
        br_taken  = br;
        x.o       = o;
        x.sel_ok  = sel;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        cur_cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        m_ill = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, i[0], ~i[0], blank(3'd7), 1'b0);
    endtask

    // One instruction: fwait/mwait idle cycles before mem_ready; abort_mem>=0 resets mid-MEM.
    task automatic run_instr(input string nm, input logic [31:0] ins, input logic br,
                             input int fwait, input int mwait, input int abort_mem,
                             output int ncyc);
        logic [6:0] op;
        logic [2:0] f3;
        logic       legal, ld, st, bra, jmp;
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
        obs_t       o;
        cur_name = nm;
        cur_cyc  = 0;
        instr    = ins;
        ncyc     = 0;
        op  = ins[6:0];
        f3  = ins[14:12];
        ld  = (op == 7'b0000011);
        st  = (op == 7'b0100011);
        bra = (op == 7'b1100011);
        jmp = (op == 7'b1101111) || (op == 7'b1100111);
        legal = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        imm = 3'd0; a = 2'd0; b = 1'b1;
        case (op)
            7'b0110011: b = 1'b0;
            7'b0010011: imm = ((f3 == 3'b001) || (f3 == 3'b101)) ? 3'd1 : 3'd0;
            7'b0100011: imm = 3'd2;
            7'b0110111: begin a = 2'd2; imm = 3'd4; end
            7'b0010111: begin a = 2'd1; imm = 3'd4; end
            7'b1101111: begin a = 2'd1; imm = 3'd5; end
            7'b1100011: begin b = 1'b0; imm = 3'd3; end
            default: ;
        endcase
        for (int i = 0; i < fwait; i++) begin
            o = blank(3'd0); o.mreq = 1'b1;
            step(1'b0, 1'b0, 1'b0, o, 1'b0); ncyc++;
        end
        o = blank(3'd0); o.mreq = 1'b1; o.irw = 1'b1;
        step(1'b0, 1'b1, 1'b0, o, 1'b0); ncyc++;
        step(1'b0, 1'b1, 1'b0, blank(3'd1), 1'b0); ncyc++;
        if (!legal) begin
            m_ill = 1'b1;
            return;
        end
        o = blank(3'd2); o.imm = imm; o.a = a; o.b = b;
        if (bra) begin
            o.pcw = 1'b1;
            o.pcs = br ? 2'd2 : 2'd0;
        end
        step(1'b0, 1'b1, br, o, 1'b1); ncyc++;
        if (bra) return;
        if (ld || st) begin
            for (int i = 0; i < mwait; i++) begin
                if (i == abort_mem) begin
                    do_reset(1);
                    return;
                end
                o = blank(3'd3); o.imm = imm; o.a = a; o.b = b; o.mreq = 1'b1; o.mwe = st;
                step(1'b0, 1'b0, 1'b0, o, 1'b1); ncyc++;
            end
            o = blank(3'd3); o.imm = imm; o.a = a; o.b = b; o.mreq = 1'b1; o.mwe = st;
            o.pcw = st;
            step(1'b0, 1'b1, 1'b0, o, 1'b1); ncyc++;
            if (st) return;
        end
        o = blank(3'd4); o.rw = 1'b1; o.pcw = 1'b1;
        o.pcs = jmp ? 2'd1 : 2'd0;
        o.wbs = ld ? 2'd1 : (jmp ? 2'd2 : 2'd0);
        step(1'b0, 1'b1, 1'b0, o, 1'b0); ncyc++;
    endtask

    // A fetch never answered requests for c_to+1 cycles (counter 0..c_to), then halts.
    task automatic run_fetch_timeout();
        obs_t o;
        cur_name = "fetch_timeout";
        cur_cyc  = 0;
        for (int i = 0; i <= c_to; i++) begin
            o = blank(3'd0); o.mreq = 1'b1;
            step(1'b0, 1'b0, 1'b0, o, 1'b0);
        end
        m_to = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; instr = 32'h0;
        @(posedge clk);
        #1;
        do_reset(2);
        chk("reset_state", int'(state), 0);
        chk("reset_mem_req", int'(mem_req), 0);

        run_instr("add", 32'h002081B3, 1'b0, 0, 0, -1, n);  chk("add_cycles", n, 4);
        run_instr("lw_wait3", 32'h0080A283, 1'b0, 0, 3, -1, n); chk("lw_wait3_cycles", n, 8);
        run_instr("lw", 32'h0080A283, 1'b0, 0, 0, -1, n);  chk("lw_cycles", n, 5);
        run_instr("beq_taken", 32'h00208463, 1'b1, 0, 0, -1, n); chk("beq_taken_cycles", n, 3);
        run_instr("beq_not", 32'h00208463, 1'b0, 0, 0, -1, n);   chk("beq_not_cycles", n, 3);
        run_instr("slli", 32'h00309093, 1'b0, 0, 0, -1, n);
        run_instr("srai", 32'h4030D093, 1'b0, 0, 0, -1, n);
        run_instr("addi", 32'h00508093, 1'b0, 0, 0, -1, n);
        run_instr("jal", 32'h010000EF, 1'b0, 0, 0, -1, n);   chk("jal_cycles", n, 4);
        run_instr("jalr", 32'h00008067, 1'b0, 0, 0, -1, n);
        run_instr("lui_fwait_lim", 32'h123450B7, 1'b0, c_to, 0, -1, n);
        run_instr("auipc", 32'h00001097, 1'b0, 0, 0, -1, n);
        run_instr("sw", 32'h0020A223, 1'b0, 0, 0, -1, n);    chk("sw_cycles", n, 4);
        run_instr("sw_mwait_lim", 32'h0020A223, 1'b0, 2, c_to, -1, n); chk("sw_lim_cycles", n, 10);
        chk("no_timeout_at_limit", int'(timeout), 0);

        run_instr("sw_reset_mid_mem", 32'h0020A223, 1'b0, 0, 5, 2, n);
        run_instr("add_after_reset", 32'h002081B3, 1'b0, 1, 0, -1, n);

        run_instr("illegal", 32'hFFFFFFFF, 1'b0, 0, 0, -1, n);
        cur_name = "illegal_halt";
        halt_cycles(20);
        chk("illegal_state", int'(state), 7);
        chk("illegal_flag", int'(illegal), 1);
        do_reset(1);
        begin
            obs_t o;
            o = blank(3'd0); o.mreq = 1'b1;
            step(1'b0, 1'b0, 1'b0, o, 1'b0);
        end
        chk("illegal_cleared", int'(illegal), 0);
        chk("state_after_rst", int'(state), 0);

        do_reset(1);
        run_fetch_timeout();
        cur_name = "timeout_halt";
        halt_cycles(5);
        chk("timeout_flag", int'(timeout), 1);
        chk("timeout_state", int'(state), 7);
        chk("timeout_mem_req", int'(mem_req), 0);

        do_reset(1);
        run_instr("add_recover", 32'h002081B3, 1'b0, 0, 0, -1, n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
